// File: rtl/nibble_serial_accumulator_pkg.sv
// Shared convolution-engine constants and the accumulator state encoding.
package conv_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int DEF_ACC_NIBBLES = 3;
    localparam int DEF_NUM_TERMS   = 9;
    localparam int TERM_CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } acc_state_e;

endpackage

// File: rtl/nibble_serial_accumulator_if.sv
// Operand/result stream bundle between the product stage and the pixel buffer.
interface nibble_serial_accumulator_if #(
    parameter int DATA_W = 12
);

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              overflow;
    logic              busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, overflow, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, overflow, busy
    );

endinterface

// File: rtl/nibble_serial_accumulator_four_bit_adder.sv
// Single 4-bit ripple-carry adder cell, time-shared across accumulator nibbles.
module four_bit_adder
    import conv_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o
);

    logic [NIBBLE_W:0] carry_s;

    // Bit-serial ripple through the four full-adder stages.
    always_comb begin
        carry_s    = {(NIBBLE_W+1){1'b0}};
        sum_o      = {NIBBLE_W{1'b0}};
        carry_s[0] = cin_i;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
            carry_s[i+1]   = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry_s[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Accumulates NUM_TERMS operands through one shared nibble adder, one nibble per cycle.
// Build option: NIBBLE_ACC_SATURATE_EN clamps the result to all-ones on first overflow.
module nibble_serial_accumulator
    import conv_pkg::*;
#(
    parameter int NUM_TERMS   = DEF_NUM_TERMS,
    parameter int ACC_NIBBLES = DEF_ACC_NIBBLES
) (
    input logic                        clk,
    input logic                        rst,
    nibble_serial_accumulator_if.slave acc_if
);

    localparam int ACC_W = NIBBLE_W * ACC_NIBBLES;
    localparam int IDX_W = (ACC_NIBBLES > 1) ? $clog2(ACC_NIBBLES) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(ACC_NIBBLES - 1);
    localparam logic [TERM_CNT_W-1:0] LAST_TERM = TERM_CNT_W'(NUM_TERMS - 1);

    acc_state_e            state_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      op_q;
    logic [IDX_W-1:0]      nib_idx_q;
    logic [TERM_CNT_W-1:0] term_cnt_q;
    logic                  carry_q;
    logic                  overflow_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [ACC_W-1:0]      out_data_q;
    logic                  busy_q;

    logic [NIBBLE_W-1:0]   a_nib_s;
    logic [NIBBLE_W-1:0]   b_nib_s;
    logic [NIBBLE_W-1:0]   sum_s;
    logic                  cout_s;
    logic                  last_nib_s;
    logic [ACC_W-1:0]      acc_wr_s;
    logic [ACC_W-1:0]      acc_d;

    four_bit_adder u_adder (
        .a_i    (a_nib_s),
        .b_i    (b_nib_s),
        .cin_i  (carry_q),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    // Nibble select into the shared adder and write-back of its sum.
    always_comb begin
        a_nib_s    = acc_q[nib_idx_q*NIBBLE_W +: NIBBLE_W];
        b_nib_s    = op_q[nib_idx_q*NIBBLE_W +: NIBBLE_W];
        last_nib_s = (nib_idx_q == LAST_IDX);
        acc_wr_s   = acc_q;
        acc_wr_s[nib_idx_q*NIBBLE_W +: NIBBLE_W] = sum_s;
`ifdef NIBBLE_ACC_SATURATE_EN
        // Once clamped, later terms are consumed but never alter the result.
        if (overflow_q) begin
            acc_d = acc_q;
        end else if (last_nib_s && cout_s) begin
            acc_d = {ACC_W{1'b1}};
        end else begin
            acc_d = acc_wr_s;
        end
`else
        acc_d = acc_wr_s;
`endif
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            op_q        <= {ACC_W{1'b0}};
            nib_idx_q   <= {IDX_W{1'b0}};
            term_cnt_q  <= {TERM_CNT_W{1'b0}};
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_if.start) begin
                        acc_q      <= {ACC_W{1'b0}};
                        term_cnt_q <= {TERM_CNT_W{1'b0}};
                        overflow_q <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (acc_if.in_valid && in_ready_q) begin
                        op_q       <= acc_if.in_data;
                        nib_idx_q  <= {IDX_W{1'b0}};
                        carry_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    acc_q   <= acc_d;
                    carry_q <= cout_s;
                    if (last_nib_s) begin
                        term_cnt_q <= term_cnt_q + 8'd1;
                        if (cout_s) begin
                            overflow_q <= 1'b1;
                        end
                        if (term_cnt_q == LAST_TERM) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= acc_d;
                            state_q     <= ST_DONE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end else begin
                        nib_idx_q <= nib_idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // A coincident start is deliberately dropped here.
                    if (acc_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign acc_if.in_ready  = in_ready_q;
    assign acc_if.out_valid = out_valid_q;
    assign acc_if.out_data  = out_data_q;
    assign acc_if.overflow  = overflow_q;
    assign acc_if.busy      = busy_q;

endmodule

// File: doc/nibble_serial_accumulator.md
Name: nibble_serial_accumulator

Overview:
- Sequences a single 4-bit ripple adder (one four_bit_adder cell) to accumulate the multi-nibble terms of one convolution output pixel, one nibble per cycle.
- Accepts NUM_TERMS operands over a valid/ready stream, then presents the accumulated sum with a valid/ready output handshake.
- Sits between the product stage and the output-pixel buffer of the convolution engine.
- Trades adder area for latency: one shared nibble adder replaces a full-width adder.

Parameters:
- NUM_TERMS, 9, number of operands summed per output pixel (3x3 kernel); legal range 1..255.
- ACC_NIBBLES, 3, accumulator width in nibbles; accumulator width is 4*ACC_NIBBLES bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a new accumulation; honoured only in IDLE.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid & in_ready.
- in_data  input  4*ACC_NIBBLES  operand; producer zero-extends narrower products.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result when out_valid & out_ready.
- out_data  output  4*ACC_NIBBLES  accumulated sum; stable while out_valid=1.
- overflow  output  1  sticky; set if any nibble-chain carry-out occurred during the current accumulation.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, at any time, including mid-operation):
  - state=IDLE; accumulator, operand register, nibble index, term count and carry flop cleared.
  - in_ready=0, out_valid=0, out_data=0, overflow=0, busy=0.
  - No partial result survives reset.
- IDLE:
  - start=1 clears the accumulator, term count and overflow, then goes to LOAD.
  - Otherwise stay in IDLE. in_valid is ignored.
- LOAD:
  - in_ready=1.
  - On handshake: capture in_data into the operand register, set nibble index=0 and carry=0, go to ADD.
  - No handshake: stay in LOAD indefinitely.
- ADD (in_ready=0), one cycle per nibble index k from 0 to ACC_NIBBLES-1:
  - Adder inputs: A=acc[k], B=op[k], Cin=carry.
  - Write Sum into acc[k]; carry <= Cout.
  - On k=ACC_NIBBLES-1: a final Cout=1 sets overflow; term count increments.
  - If term count has reached NUM_TERMS, go to DONE; else go to LOAD.
- DONE:
  - out_valid=1 and out_data=accumulator.
  - Leave to IDLE on out_ready=1; out_valid=0 the following cycle.
- Latency:
  - Each term costs 1 LOAD cycle plus ACC_NIBBLES ADD cycles (minimum 4 cycles per term at defaults).
  - First out_valid appears NUM_TERMS*(ACC_NIBBLES+1)+1 cycles after start, with in_valid held high (37 at defaults).
- Arithmetic: unsigned, modulo 2^(4*ACC_NIBBLES); overflow is the only indication of wrap.
- Boundaries:
  - start outside IDLE is ignored.
  - start together with out_ready in DONE returns to IDLE only; a new start is needed the following cycle.
  - out_ready while out_valid=0 has no effect.
  - NUM_TERMS=1 goes straight from one ADD sequence to DONE.

Optional Feature:
- Macro: NIBBLE_ACC_SATURATE_EN.
- Defined:
  - On the first overflow, the accumulator is forced to all-ones.
  - Remaining terms are still handshaked (same cycle count) but do not modify the accumulator.
  - out_data=2^(4*ACC_NIBBLES)-1 and overflow=1.
- Undefined: result wraps; overflow still set.

Decomposition:
- Package conv_pkg:
  - NIBBLE_W=4.
  - State encoding typedef: IDLE, LOAD, ADD, DONE.
  - Default ACC_NIBBLES and NUM_TERMS constants shared with the convolution top.
- Sub-module: one instance of four_bit_adder as the nibble datapath.
- Nibble select and write-back muxes stay in this block.

Test Plan:
- Reset and default accumulation:
  - Reset, start, 9 operands of 0x0E1 (225) with in_valid held high.
  - Expect out_data=0x7E9 (2025), overflow=0, out_valid at cycle 37 after start.
- Carry ripple across nibbles:
  - NUM_TERMS=2, operands 0x00F and 0x001.
  - Expect out_data=0x010; carry propagates nibble 0 to nibble 1.
- Overflow, wrap build:
  - NUM_TERMS=2, operands 0xFFF and 0x002, macro off.
  - Expect out_data=0x001, overflow=1.
- Overflow, saturating build:
  - Same stimulus with NIBBLE_ACC_SATURATE_EN defined.
  - Expect out_data=0xFFF, overflow=1.
- Backpressure and ignored start:
  - Drop in_valid for 5 cycles mid-stream; expect no progress and an unchanged result.
  - Hold out_ready=0 for 10 cycles in DONE; expect out_data stable and start ignored.
- Reset mid-operation:
  - Assert rst during ADD of term 4.
  - Expect all outputs 0 immediately.
  - A fresh start then gives a correct full sum, with no stale accumulator or overflow.
